// File: rtl/ps2_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ps2_scan_sequencer
// Function : PS/2 keyboard receive path. Syncs ps2_clk/data, checks 11-bit
//            frames, folds E0/F0 prefixes into key events, queues them in a
//            FWFT FIFO and tracks the W/A/S/D held-key bitmap.
// Options  : define PS2_WATCHDOG_EN to abort partial frames after
//            TIMEOUT_CYCLES clk cycles without a ps2_clk falling edge.
// Revision : 1.0  initial release
// ============================================================================
module ps2_scan_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [3:0] held,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] KEY_W    = 8'h1D;
  localparam logic [7:0] KEY_A    = 8'h1C;
  localparam logic [7:0] KEY_S    = 8'h1B;
  localparam logic [7:0] KEY_D    = 8'h23;

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
    end
  endgenerate

  // Synchronizers reset to 1 (idle bus level) so reset release never looks like an edge.
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_prev_q;
  logic                   ps2c_s;
  logic                   data_s;
  logic                   fe;

  assign ps2c_s = clk_sync_q[SYNC_STAGES-1];
  assign data_s = dat_sync_q[SYNC_STAGES-1];
  assign fe     = clk_prev_q & ~ps2c_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], data};
      clk_prev_q <= ps2c_s;
    end
  end

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       par_q, par_d;
  logic       wd_expired;

`ifdef PS2_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;

  // The fe cycle itself counts as 1, so frame_err lands TIMEOUT_CYCLES cycles after it.
  assign wd_expired = ~fe && (state_q != ST_IDLE) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else if (fe) begin
      wd_q <= WD_W'(1);
    end else if (state_q == ST_IDLE) begin
      wd_q <= '0;
    end else if (!wd_expired) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    if (fe) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d = ST_DATA;
            cnt_d   = 3'd0;
          end
        end
        ST_DATA: begin
          shreg_d = {data_s, shreg_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_d   = data_s;
          state_d = ST_STOP;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (wd_expired) begin
      state_d = ST_IDLE;
    end
  end

  logic frame_good;
  logic byte_vld_d;
  logic frame_err_d;

  always_comb begin
    frame_good  = data_s & (^{shreg_q, par_q});
    byte_vld_d  = 1'b0;
    frame_err_d = wd_expired;
    if (fe && state_q == ST_STOP) begin
      byte_vld_d  = frame_good;
      frame_err_d = ~frame_good;
    end
  end

  logic       byte_vld_q;
  logic [7:0] byte_q;
  logic       frame_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_vld_q  <= 1'b0;
      byte_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
      if (byte_vld_d) begin
        byte_q <= shreg_q;
      end
    end
  end

  logic       ext_f_q, ext_f_d;
  logic       brk_f_q, brk_f_d;
  logic [3:0] held_q, held_d;
  logic       push;

  assign push = byte_vld_q && (byte_q != CODE_EXT) && (byte_q != CODE_BRK);

  always_comb begin
    ext_f_d = ext_f_q;
    brk_f_d = brk_f_q;
    held_d  = held_q;
    if (frame_err_q) begin
      ext_f_d = 1'b0;
      brk_f_d = 1'b0;
    end else if (byte_vld_q) begin
      if (byte_q == CODE_EXT) begin
        ext_f_d = 1'b1;
      end else if (byte_q == CODE_BRK) begin
        brk_f_d = 1'b1;
      end else begin
        ext_f_d = 1'b0;
        brk_f_d = 1'b0;
        // Extended codes share numbers with W/A/S/D but are different keys.
        if (!ext_f_q) begin
          case (byte_q)
            KEY_W:   held_d[0] = ~brk_f_q;
            KEY_A:   held_d[1] = ~brk_f_q;
            KEY_S:   held_d[2] = ~brk_f_q;
            KEY_D:   held_d[3] = ~brk_f_q;
            default: held_d    = held_q;
          endcase
        end
      end
    end
  end

  logic [AW:0] wr_q, rd_q;
  logic [9:0]  mem_q [FIFO_DEPTH];
  logic [9:0]  last_q;
  logic [9:0]  head;
  logic        empty, full, pop, wr_en, overflow_q;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = ~empty & evt_ready;
  assign wr_en = push & (~full | pop);
  assign head  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_q[AW-1:0]] <= {byte_q, ext_f_q, brk_f_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_f_q    <= 1'b0;
      brk_f_q    <= 1'b0;
      held_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      last_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      ext_f_q    <= ext_f_d;
      brk_f_q    <= brk_f_d;
      held_q     <= held_d;
      overflow_q <= push & full & ~pop;
      if (wr_en) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      if (!empty) begin
        last_q <= head;
      end
    end
  end

  assign evt_valid                      = ~empty;
  assign {evt_code, evt_ext, evt_break} = empty ? last_q : head;
  assign held                           = held_q;
  assign frame_err                      = frame_err_q;
  assign overflow                       = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_scan_sequencer
// Function : Directed, table-driven bench for ps2_scan_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_scan_sequencer;

`ifdef PS2_WATCHDOG_EN
  localparam int TB_TIMEOUT = 200;
`else
  localparam int TB_TIMEOUT = 50000;
`endif

  logic       clk = 1'b0;
  logic       rst, ps2_clk, data, evt_ready;
  logic       evt_valid, evt_ext, evt_break, frame_err, overflow;
  logic [7:0] evt_code;
  logic [3:0] held;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int ferr_cyc  = 0;
  int ovf_cyc   = 0;
  int ferr_at   = -1;
  logic [9:0] evq[$];

  ps2_scan_sequencer #(
    .FIFO_DEPTH    (4),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .data     (data),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code (evt_code),
    .evt_ext  (evt_ext),
    .evt_break(evt_break),
    .held     (held),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (evt_valid && evt_ready) evq.push_back({evt_code, evt_ext, evt_break});
      if (frame_err) begin
        ferr_cyc <= ferr_cyc + 1;
        if (ferr_at < 0) ferr_at <= cyc;
      end
      if (overflow) ovf_cyc <= ovf_cyc + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic [10:0] fbits(input logic [7:0] c, input logic bad);
    return {1'b1, (~(^c)) ^ bad, c, 1'b0};
  endfunction

  // Ends with ps2_clk driven low 1ns after a posedge.
  task automatic fall_bit(input logic b);
    @(posedge clk); #1 data = b;
    repeat (39) @(posedge clk);
    #1 ps2_clk = 1'b0;
  endtask

  task automatic rise();
    repeat (40) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_bit(input logic b);
    fall_bit(b);
    rise();
  endtask

  task automatic send_frame(input logic [7:0] c, input logic bad);
    logic [10:0] f;
    f = fbits(c, bad);
    for (int i = 0; i < 11; i++) send_bit(f[i]);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, evt_valid, 0);
    chk({tag, "_code"},  evt_code, 0);
    chk({tag, "_ext"},   evt_ext, 0);
    chk({tag, "_brk"},   evt_break, 0);
    chk({tag, "_held"},  held, 0);
    chk({tag, "_ferr"},  frame_err, 0);
    chk({tag, "_ovf"},   overflow, 0);
  endtask

  typedef struct {
    logic [7:0] code;
    logic       bad;
    logic       has_evt;
    logic [9:0] evt;
    logic [3:0] held;
    int         ferr;
  } vec_t;

  localparam int NV = 23;
  vec_t vt[NV];

  initial begin
    logic [10:0] f;
    logic [7:0]  exp_codes[4];
    int          f0, o0, t0;

    vt[0]  = '{8'h1C, 1'b0, 1'b1, {8'h1C, 2'b00}, 4'b0011, 0};
    vt[1]  = '{8'hF0, 1'b0, 1'b0, 10'h0,          4'b0011, 0};
    vt[2]  = '{8'h1C, 1'b0, 1'b1, {8'h1C, 2'b01}, 4'b0001, 0};
    vt[3]  = '{8'hE0, 1'b0, 1'b0, 10'h0,          4'b0001, 0};
    vt[4]  = '{8'hF0, 1'b0, 1'b0, 10'h0,          4'b0001, 0};
    vt[5]  = '{8'h75, 1'b0, 1'b1, {8'h75, 2'b11}, 4'b0001, 0};
    vt[6]  = '{8'h1B, 1'b1, 1'b0, 10'h0,          4'b0001, 1};
    vt[7]  = '{8'h1B, 1'b0, 1'b1, {8'h1B, 2'b00}, 4'b0101, 0};
    vt[8]  = '{8'hE0, 1'b0, 1'b0, 10'h0,          4'b0101, 0};
    vt[9]  = '{8'h1D, 1'b0, 1'b1, {8'h1D, 2'b10}, 4'b0101, 0};
    vt[10] = '{8'hF0, 1'b0, 1'b0, 10'h0,          4'b0101, 0};
    vt[11] = '{8'h1D, 1'b0, 1'b1, {8'h1D, 2'b01}, 4'b0100, 0};
    vt[12] = '{8'hF0, 1'b0, 1'b0, 10'h0,          4'b0100, 0};
    vt[13] = '{8'h1B, 1'b0, 1'b1, {8'h1B, 2'b01}, 4'b0000, 0};
    vt[14] = '{8'h23, 1'b0, 1'b1, {8'h23, 2'b00}, 4'b1000, 0};
    vt[15] = '{8'hF0, 1'b0, 1'b0, 10'h0,          4'b1000, 0};
    vt[16] = '{8'h23, 1'b0, 1'b1, {8'h23, 2'b01}, 4'b0000, 0};
    vt[17] = '{8'hE0, 1'b0, 1'b0, 10'h0,          4'b0000, 0};
    vt[18] = '{8'h55, 1'b1, 1'b0, 10'h0,          4'b0000, 1};
    vt[19] = '{8'h1D, 1'b0, 1'b1, {8'h1D, 2'b00}, 4'b0001, 0};
    vt[20] = '{8'hF0, 1'b0, 1'b0, 10'h0,          4'b0001, 0};
    vt[21] = '{8'hE0, 1'b0, 1'b0, 10'h0,          4'b0001, 0};
    vt[22] = '{8'h23, 1'b0, 1'b1, {8'h23, 2'b11}, 4'b0001, 0};

    rst = 1'b1; ps2_clk = 1'b1; data = 1'b1; evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("reset");

    // First frame with exact event latency from the stop-bit falling edge.
    evq.delete();
    f = fbits(8'h1D, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    fall_bit(f[10]);
    repeat (4) @(negedge clk);
    chk("lat_before", evt_valid, 0);
    @(negedge clk);
    chk("lat_valid", evt_valid, 1);
    chk("lat_code", evt_code, 8'h1D);
    chk("lat_extbrk", {evt_ext, evt_break}, 2'b00);
    chk("lat_held", held, 4'b0001);
    rise();
    chk("first_nevt", evq.size(), 1);
    chk("first_evt", evq[0], {8'h1D, 2'b00});

    for (int i = 0; i < NV; i++) begin
      evq.delete();
      f0 = ferr_cyc;
      send_frame(vt[i].code, vt[i].bad);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_nevt", i), evq.size(), vt[i].has_evt ? 1 : 0);
      if (vt[i].has_evt && evq.size() > 0) chk($sformatf("v%0d_evt", i), evq[0], vt[i].evt);
      chk($sformatf("v%0d_held", i), held, vt[i].held);
      chk($sformatf("v%0d_ferr", i), ferr_cyc - f0, vt[i].ferr);
    end

    // Overflow: fifth event is dropped while the consumer stalls.
    @(posedge clk); #1 evt_ready = 1'b0;
    evq.delete();
    o0 = ovf_cyc;
    send_frame(8'h15, 1'b0);
    send_frame(8'h16, 1'b0);
    send_frame(8'h1E, 1'b0);
    send_frame(8'h26, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("full_ovf", ovf_cyc - o0, 0);
    chk("full_valid", evt_valid, 1);
    chk("full_head", evt_code, 8'h15);
    send_frame(8'h25, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("drop_ovf", ovf_cyc - o0, 1);
    chk("drop_head", evt_code, 8'h15);
    chk("drop_held", held, 4'b0001);
    @(posedge clk); #1 evt_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    exp_codes = '{8'h15, 8'h16, 8'h1E, 8'h26};
    chk("drain_n", evq.size(), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("drain%0d", k), evq[k], {exp_codes[k], 2'b00});
    chk("empty_valid", evt_valid, 0);
    chk("empty_hold", evt_code, 8'h26);

    // Push into a full FIFO in the same cycle as a pop: no drop.
    @(posedge clk); #1 evt_ready = 1'b0;
    evq.delete();
    o0 = ovf_cyc;
    send_frame(8'h2E, 1'b0);
    send_frame(8'h36, 1'b0);
    send_frame(8'h3D, 1'b0);
    send_frame(8'h3E, 1'b0);
    f = fbits(8'h46, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    fall_bit(f[10]);
    repeat (3) @(posedge clk);
    #1 evt_ready = 1'b1;
    @(posedge clk);
    #1 evt_ready = 1'b0;
    rise();
    chk("pp_ovf", ovf_cyc - o0, 0);
    chk("pp_pop_n", evq.size(), 1);
    chk("pp_pop", evq[0], {8'h2E, 2'b00});
    evq.delete();
    @(posedge clk); #1 evt_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    exp_codes = '{8'h36, 8'h3D, 8'h3E, 8'h46};
    chk("pp_drain_n", evq.size(), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("pp_drain%0d", k), evq[k], {exp_codes[k], 2'b00});

    // Partial frame: start bit plus three data bits, then ps2_clk parks high.
    evq.delete();
    f0 = ferr_cyc;
    ferr_at = -1;
    f = fbits(8'h1C, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(f[i]);
    fall_bit(f[3]);
    t0 = cyc;
    rise();
    repeat (300) @(posedge clk);
    @(negedge clk);
`ifdef PS2_WATCHDOG_EN
    chk("wd_ferr_n", ferr_cyc - f0, 1);
    chk("wd_ferr_at", ferr_at, t0 + TB_TIMEOUT + 2);
    chk("wd_nevt", evq.size(), 0);
    send_frame(8'h1C, 1'b0);
`else
    chk("stall_ferr_n", ferr_cyc - f0, 0);
    chk("stall_nevt", evq.size(), 0);
    for (int i = 4; i < 11; i++) send_bit(f[i]);
`endif
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("resume_nevt", evq.size(), 1);
    chk("resume_evt", evq[0], {8'h1C, 2'b00});
    chk("resume_held", held, 4'b0011);

    // Reset in the middle of a frame with a queued event and keys held.
    @(posedge clk); #1 evt_ready = 1'b0;
    send_frame(8'h1D, 1'b0);
    f = fbits(8'h1B, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(f[i]);
    fall_bit(f[4]);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_idle_outputs("midrst");
    ps2_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    evq.delete();
    f0 = ferr_cyc;
    evt_ready = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    chk("postrst_nevt", evq.size(), 0);
    chk("postrst_ferr", ferr_cyc - f0, 0);
    chk("postrst_valid", evt_valid, 0);
    chk("postrst_held", held, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
